rotate_right_serial: RTL and testbench

ROTATE_RIGHT_SERIAL -- requirements
Module: rotate_right_serial

---
 rtl/rotate_right_serial_pkg.sv | 20 ++
 rtl/rotate_right_serial.sv | 89 ++++++++
 tb/tb_rotate_right_serial.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rotate_right_serial_pkg.sv
// Shared types and width helpers for the barrel-shifter family.
// Holds the serial rotator FSM encoding and the shift-amount width rule.
package rotate_right_serial_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } rot_state_e;

    // One extra bit so a full-width amount (== N) is representable on the port.
    function automatic int unsigned shift_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rotate_right_serial.sv
// Serial rotate-right: undoes a left rotation by in_shift, one bit position per cycle.
// Valid/ready on both sides; one word in flight at a time.
module rotate_right_serial
    import rotate_right_serial_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned SW = shift_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shift,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [SW-1:0] out_shift,
    output logic          busy
);

    localparam int unsigned CW = count_width(N);

    rot_state_e    r_state;
    rot_state_e    w_state_next;
    logic [N-1:0]  r_data;
    logic [N-1:0]  w_data_next;
    logic [SW-1:0] r_shift;
    logic [SW-1:0] w_shift_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_k;

    // Amount modulo N is just the low bits because N is a power of two.
    assign w_k = in_shift[CW-1:0];

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_shift_next = r_shift;
        w_count_next = r_count;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_data_next  = in_data;
                    w_shift_next = in_shift;
                    w_count_next = w_k;
                    w_state_next = (w_k == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                w_data_next  = {r_data[0], r_data[N-1:1]};
                w_count_next = r_count - 1'b1;
                if (r_count == CW'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_shift <= w_shift_next;
            r_count <= w_count_next;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign out_data  = r_data;
    assign out_shift = r_shift;

endmodule

// File: tb/tb_rotate_right_serial.sv
// Bench for rotate_right_serial: vector table, random round trips against a left-rotate
// model, backpressure and mid-shift reset, with a scoreboard queue of expected words.
module tb_rotate_right_serial;

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_shift;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [SW-1:0] out_shift;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  data;
        logic [SW-1:0] shift;
        int            lat;
    } exp_t;

    typedef struct {
        logic [N-1:0]  data;
        logic [SW-1:0] shift;
        logic [N-1:0]  exp_data;
        int            exp_lat;
        int            hold;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    rotate_right_serial #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rotl_model(input logic [N-1:0] x, input int s);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[(i + s) % N] = x[i];
        end
        return r;
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic run_word(input logic [N-1:0] d, input logic [SW-1:0] s,
                            input logic [N-1:0] exp_d, input int exp_lat, input int hold);
        exp_t e;
        int   cyc;
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_shift = '0;
        sb_q.push_back('{data: exp_d, shift: s, lat: exp_lat});
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            chk("busy_while_shifting", busy, 1);
            chk("in_ready_while_shifting", in_ready, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("out_valid_within_budget", out_valid, 1);
        if (out_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_shift", out_shift, e.shift);
            chk("latency", cyc, e.lat);
            chk("busy_in_done", busy, 1);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            in_shift = 4'd1;
            @(posedge clk);
            #1;
            chk("bp_out_valid_held", out_valid, 1);
            chk("bp_out_data_held", out_data, exp_d);
            chk("bp_out_shift_held", out_shift, s);
            chk("bp_in_ready_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_handshake_out_valid", out_valid, 0);
        chk("post_handshake_in_ready", in_ready, 1);
        chk("post_handshake_busy", busy, 0);
    endtask

    initial begin
        logic [N-1:0]  x;
        logic [SW-1:0] s;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        out_ready = 1'b0;

        vecs.push_back('{data: 8'h96, shift: 4'd0,  exp_data: 8'h96, exp_lat: 0, hold: 0});
        vecs.push_back('{data: 8'h96, shift: 4'd3,  exp_data: 8'hD2, exp_lat: 3, hold: 0});
        vecs.push_back('{data: 8'h96, shift: 4'd11, exp_data: 8'hD2, exp_lat: 3, hold: 0});
        vecs.push_back('{data: 8'hB4, shift: 4'd5,  exp_data: 8'hA5, exp_lat: 5, hold: 0});
        vecs.push_back('{data: 8'h96, shift: 4'd3,  exp_data: 8'hD2, exp_lat: 3, hold: 4});
        vecs.push_back('{data: 8'h01, shift: 4'd7,  exp_data: 8'h02, exp_lat: 7, hold: 0});
        vecs.push_back('{data: 8'h81, shift: 4'd1,  exp_data: 8'hC0, exp_lat: 1, hold: 0});
        vecs.push_back('{data: 8'h80, shift: 4'd8,  exp_data: 8'h80, exp_lat: 0, hold: 1});
        vecs.push_back('{data: 8'hFF, shift: 4'd15, exp_data: 8'hFF, exp_lat: 7, hold: 0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_shift", out_shift, 0);

        // First word offered in the same cycle reset is released.
        reset = 1'b1;
        foreach (vecs[i]) begin
            run_word(vecs[i].data, vecs[i].shift, vecs[i].exp_data, vecs[i].exp_lat,
                     vecs[i].hold);
        end

        for (int i = 0; i < 24; i++) begin
            x = N'($urandom_range(0, 255));
            s = SW'($urandom_range(0, 15));
            run_word(rotl_model(x, int'(s)), s, x, int'(s) % N, 0);
        end

        // Abort a word part way through its rotation.
        in_valid = 1'b1;
        in_data  = 8'h96;
        in_shift = 4'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_shift_busy", busy, 1);
        chk("mid_shift_out_valid", out_valid, 0);
        chk("mid_shift_partial_data", out_data, 8'hA5);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_shift", out_shift, 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_word", out_valid, 0);
        end
        out_ready = 1'b0;

        run_word(8'h3C, 4'd2, 8'h0F, 2, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
